uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named as in the codebase: clk and rst.
REQ-002 Parameter CLKS_PER_BIT, default 104, SHALL set the clk cycles per serial bit; legal range 2..65535.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  asynchronous active-high reset.
REQ-005 Port data  input  8  byte from the upstream change logger, valid while data_valid=1.
REQ-006 Port data_valid  input  1  upstream byte available; held until next is seen, dropped the cycle after.
REQ-007 Port next  output  1  single-cycle pulse acknowledging that data was consumed.
REQ-008 Port cts  input  1  clear-to-send from host; 1 permits starting a frame.
REQ-009 Port txd  output  1  serial line, idle high, LSB first.
REQ-010 Port busy  output  1  high whenever a frame is in progress (state != IDLE).

Function
REQ-011 The block SHALL use states IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-012 Acceptance: on an edge in IDLE with data_valid=1 and cts=1, the block SHALL latch data into an 8-bit shift register, go to START, drive txd=0, load the baud counter with CLKS_PER_BIT-1, and register next=1.
REQ-013 next SHALL be high for exactly the one cycle following acceptance and 0 otherwise; no second acceptance SHALL occur before the frame returns to IDLE.
REQ-014 Each bit SHALL last exactly CLKS_PER_BIT cycles; the baud counter (16 bits) counts down, and the bit advances when it reads 0, reloading CLKS_PER_BIT-1.
REQ-015 START -> DATA: txd = shreg[0]; DATA shifts right once per bit; after the 8th bit, go to PARITY (macro on) or STOP (macro off).
REQ-016 STOP SHALL drive txd=1 for one bit time, then go to IDLE with txd=1.
REQ-017 Frame period for back-to-back bytes SHALL be 10*CLKS_PER_BIT+1 cycles (11*CLKS_PER_BIT+1 with parity), i.e. at least one IDLE cycle between frames.
REQ-018 cts SHALL be sampled only in IDLE; deasserting cts mid-frame SHALL NOT abort or stretch the frame.
REQ-019 data_valid=1 with cts=0 SHALL leave the block in IDLE, next=0, txd=1, data not consumed.
REQ-020 data and data_valid changes after acceptance SHALL NOT affect the frame in progress.

Reset
REQ-021 While rst=1 (asynchronously): state=IDLE, txd=1, next=0, busy=0, baud counter=0, shift register=0, bit counter=0.
REQ-022 Reset mid-frame SHALL immediately return txd high and abandon the byte; the first edge after rst release with data_valid=1, cts=1 SHALL accept normally.

Configuration
REQ-023 Macro UART_TX_PARITY_EN defined: the PARITY state SHALL transmit one even-parity bit (XOR of the 8 latched data bits) for one bit time between DATA and STOP.
REQ-024 Macro UART_TX_PARITY_EN undefined: no PARITY state, no parity logic; DATA goes directly to STOP (8N1).

Verification
REQ-025 CLKS_PER_BIT=4, cts=1, data=0xA5 held valid -> next pulses 1 cycle; txd = 0,1,0,1,0,0,1,0,1,1 each 4 cycles; busy high 40 cycles.
REQ-026 Upstream model (drops data_valid the cycle after next, reloads 1 cycle later) sending 0x00,0xFF,0x3C -> exactly three next pulses, frames spaced 41 cycles, bytes decoded in order.
REQ-027 cts=0, data_valid=1 for 50 cycles -> txd=1, next=0, busy=0; cts->1 -> accept on next edge; cts->0 during bit 3 -> frame completes unaltered.
REQ-028 rst pulsed during DATA bit 5 of 0x55 -> txd=1 and busy=0 immediately; after release 0x81 transmits correctly.
REQ-029 UART_TX_PARITY_EN defined, CLKS_PER_BIT=4, data=0x07 -> parity bit 1 after data bits, frame 44 cycles; data=0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter (8N1) with clear-to-send gating and a one-cycle consume pulse.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       next,
    input  logic       cts,
    output logic       txd,
    output logic       busy
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t      state, state_n;
    logic [15:0] baud_cnt, baud_cnt_n;
    logic [7:0]  shreg, shreg_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic        txd_n, next_n;
`ifdef UART_TX_PARITY_EN
    logic        par_bit, par_bit_n;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
            next     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            txd      <= txd_n;
            next     <= next_n;
`ifdef UART_TX_PARITY_EN
            par_bit  <= par_bit_n;
`endif
        end
    end

    // txd is registered: each branch computes the line level for the coming bit time.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        txd_n      = txd;
        next_n     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_bit_n  = par_bit;
`endif
        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (data_valid && cts) begin
                    state_n    = START;
                    shreg_n    = data;
                    baud_cnt_n = BAUD_RELOAD;
                    bit_cnt_n  = '0;
                    txd_n      = 1'b0;
                    next_n     = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_bit_n  = ^data;
`endif
                end
            end
            START: begin
                if (baud_cnt == 16'd0) begin
                    state_n    = DATA;
                    baud_cnt_n = BAUD_RELOAD;
                    bit_cnt_n  = '0;
                    txd_n      = shreg[0];
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end
            DATA: begin
                if (baud_cnt == 16'd0) begin
                    baud_cnt_n = BAUD_RELOAD;
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        txd_n   = par_bit;
`else
                        state_n = STOP;
                        txd_n   = 1'b1;
`endif
                    end else begin
                        shreg_n   = {1'b0, shreg[7:1]};
                        txd_n     = shreg[1];
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_cnt == 16'd0) begin
                    state_n    = STOP;
                    baud_cnt_n = BAUD_RELOAD;
                    txd_n      = 1'b1;
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end
`endif
            STOP: begin
                if (baud_cnt == 16'd0) begin
                    state_n = IDLE;
                    txd_n   = 1'b1;
                end else begin
                    baud_cnt_n = baud_cnt - 16'd1;
                end
            end
            default: begin
                state_n = IDLE;
                txd_n   = 1'b1;
            end
        endcase
    end

endmodule
